aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
- Iterative AES key-expansion engine covering AES-128, AES-192 and AES-256, selected at run time.
- Generates one 32-bit schedule word per clock and derives Rcon internally.
- Streams each 128-bit round key to the cipher datapath as soon as its 4 words exist.
- Supersedes the single-round subkey generator: one start pulse yields the complete schedule.

Parameters:
- WORD_LEN, 32, schedule word width; fixed by AES, only 32 is legal.
- KEY_LEN_MAX, 256, width of the key_in port.
- RK_LEN, 128, round-key width; must equal 4*WORD_LEN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- key_in  input  KEY_LEN_MAX  cipher key, left-aligned. AES-128 uses [255:128]; AES-192 uses [255:64]; unused LSBs are ignored.
- key_mode  input  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved. Sampled with start.
- start  input  1  one-cycle request; honoured only in IDLE.
- busy  output  1  schedule generation in progress.
- rk_valid  output  1  one-cycle strobe: rk_out/rk_idx hold a new round key.
- rk_idx  output  4  round number 0..Nr of rk_out.
- rk_out  output  RK_LEN  round key, w[4r] in bits [127:96].
- done  output  1  one-cycle pulse, coincident with the final rk_valid.
- mode_err  output  1  one-cycle pulse when start arrives with key_mode=11.

Behaviour:
- Reset values: busy=0, rk_valid=0, rk_idx=0, rk_out=0, done=0, mode_err=0, FSM in IDLE, Rcon register=8'h01.
- Mode constants: Nk=4/6/8, Nr=10/12/14, total words Nw=4*(Nr+1)=44/52/60.
- FSM states: IDLE, GEN.
- IDLE -> GEN on start with a legal key_mode: latch key_in, Nk, Nr; clear word counter i (6 bits) and phase counter j=i mod Nk (3 bits, no divider). busy goes high on the next edge.
- start with key_mode=11: mode_err pulses, FSM stays IDLE.
- start while in GEN is ignored (no restart, no error).
- Word generation: in GEN, exactly one word w[i] per clock.
  - i<Nk: w[i] = key word i, taken MSB-first.
  - Otherwise: temp = w[i-1].
  - If j==0: temp = SubWord(RotWord(temp)) ^ {Rcon, 24'h0}, then Rcon <= xtime(Rcon) = {Rcon[6:0],0} ^ (Rcon[7] ? 8'h1b : 0).
  - Else if Nk==8 and j==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
- Storage: an 8-word shift window holds history; w[i-1]=win[0], w[i-Nk]=win[Nk-1].
- SubWord uses 4 instances of the existing combinational S-box.
- Round-key output:
  - A 4-word accumulator collects w[4r..4r+3].
  - On the edge that registers w[4r+3]: rk_out is loaded, rk_idx=r, rk_valid=1 for one cycle.
  - rk_out holds its value until the next round key.
  - AES-192 round keys straddle Nk groups; that is expected and needs no special handling.
- Latency: with start sampled at edge E, round key r appears after edge E+4(r+1). The final round key and done appear after edge E+Nw (44/52/60).
- On that final edge: busy<=0 and FSM<=IDLE. A new start is accepted on the immediately following edge.
- Reset mid-GEN: immediate abort, all outputs return to reset values, and no partial strobe is emitted afterwards.

Optional Feature:
- Macro: AES_KEYSCHED_STORE_EN.
- When defined:
  - Adds a 15x128 round-key register file, written on every rk_valid.
  - Adds ports rk_rd_idx (input 4) and rk_rd_data (output 128), with a combinational read.
  - Contents persist after done until overwritten by the next run or cleared by reset.
  - Reads with rk_rd_idx>Nr of the last run return 0.
- When undefined: the ports still exist, rk_rd_data is tied to 0, and no storage is inferred.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - rk_idx 1 = a0fafe1788542cb123a339392a6c7605.
  - rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done exactly 44 cycles after start; 11 rk_valid strobes total.
- AES-192, key 000102...17 -> 13 strobes; rk_idx 12 = a4970a331a78dc09c418c271e3a41d5d; done at +52.
- AES-256, key 000102...1f -> 15 strobes; rk_idx 14 = 24fc79ccbf0979e9371ac23c6d68de36; done at +60.
- key_mode=11 with start -> mode_err=1 for one cycle, busy stays 0. Then start during an AES-128 run at cycle +10 -> ignored; the run completes unchanged.
- reset asserted at cycle +20 of an AES-256 run -> all outputs 0 immediately. A new AES-128 run then yields correct keys, confirming Rcon restarted at 01.
- With AES_KEYSCHED_STORE_EN: after the AES-128 run, rk_rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6, and rk_rd_idx=12 -> 0.

Source files
------------

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128/192/256 key expansion.
// One 32-bit schedule word is produced per clock. Each 128-bit round key is
// streamed out as soon as its fourth word is registered.
// Optional round-key register file: define AES_KEYSCHED_STORE_EN.
module aes_key_schedule #(
  parameter int WORD_LEN    = 32,
  parameter int KEY_LEN_MAX = 256,
  parameter int RK_LEN      = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [KEY_LEN_MAX-1:0] key_in,
  input  logic [1:0]             key_mode,
  input  logic                   start,
  output logic                   busy,
  output logic                   rk_valid,
  output logic [3:0]             rk_idx,
  output logic [RK_LEN-1:0]      rk_out,
  output logic                   done,
  output logic                   mode_err,
  input  logic [3:0]             rk_rd_idx,
  output logic [RK_LEN-1:0]      rk_rd_data
);

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  // Forward S-box. Entry 0 sits in the most significant byte, so the
  // lookup uses the complemented index (255 - x == ~x for 8 bits).
  localparam logic [255:0][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX_TBL[~x];
  endfunction

  state_t                state_q, state_d;
  logic [KEY_LEN_MAX-1:0] key_q, key_d;
  logic [2:0]            nk_m1_q, nk_m1_d;   // Nk-1: 3/5/7
  logic [3:0]            nr_q, nr_d;
  logic [5:0]            i_q, i_d;           // word counter
  logic [2:0]            j_q, j_d;           // i mod Nk
  logic [7:0]            rcon_q, rcon_d;
  logic [WORD_LEN-1:0]   win_q [8];
  logic [WORD_LEN-1:0]   win_d [8];
  logic [WORD_LEN-1:0]   acc_q [3];
  logic [WORD_LEN-1:0]   acc_d [3];
  logic [RK_LEN-1:0]     rk_out_q, rk_out_d;
  logic [3:0]            rk_idx_q, rk_idx_d;
  logic                  rk_valid_q, rk_valid_d;
  logic                  done_q, done_d;
  logic                  mode_err_q, mode_err_d;

  logic                  start_ok, mode_bad, last_word;
  logic [WORD_LEN-1:0]   key_w [8];
  logic [WORD_LEN-1:0]   w_prev, w_back, sub_in, sub_out, w_new;

  // Split the latched key into MSB-first schedule words.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_key_w
      assign key_w[gi] = key_q[KEY_LEN_MAX-1-WORD_LEN*gi -: WORD_LEN];
    end
    for (gi = 0; gi < 4; gi++) begin : g_sub
      assign sub_out[8*gi +: 8] = sbox_lookup(sub_in[8*gi +: 8]);
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && key_mode != 2'b11) state_d = GEN;
      GEN:     if (last_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and control decodes.
  always_comb begin
    busy      = (state_q == GEN);
    start_ok  = (state_q == IDLE) && start && (key_mode != 2'b11);
    mode_bad  = (state_q == IDLE) && start && (key_mode == 2'b11);
    last_word = (state_q == GEN) && (i_q == {nr_q, 2'b11});
    rk_valid  = rk_valid_q;
    rk_idx    = rk_idx_q;
    rk_out    = rk_out_q;
    done      = done_q;
    mode_err  = mode_err_q;
  end

  // Next schedule word from the history window.
  always_comb begin
    w_prev = win_q[0];
    w_back = win_q[nk_m1_q];
    sub_in = (j_q == 3'd0) ? {w_prev[WORD_LEN-9:0], w_prev[WORD_LEN-1 -: 8]} : w_prev;
    if (i_q <= {3'b000, nk_m1_q})
      w_new = key_w[i_q[2:0]];
    else if (j_q == 3'd0)
      w_new = w_back ^ sub_out ^ {rcon_q, {(WORD_LEN-8){1'b0}}};
    else if (nk_m1_q == 3'd7 && j_q == 3'd4)
      w_new = w_back ^ sub_out;
    else
      w_new = w_back ^ w_prev;
  end

  // Datapath next-state: key latch, counters, Rcon, window, round-key output.
  always_comb begin
    key_d      = key_q;
    nk_m1_d    = nk_m1_q;
    nr_d       = nr_q;
    i_d        = i_q;
    j_d        = j_q;
    rcon_d     = rcon_q;
    win_d      = win_q;
    acc_d      = acc_q;
    rk_out_d   = rk_out_q;
    rk_idx_d   = rk_idx_q;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;
    mode_err_d = mode_bad;
    if (start_ok) begin
      key_d  = key_in;
      i_d    = 6'd0;
      j_d    = 3'd0;
      rcon_d = 8'h01;
      case (key_mode)
        2'b00:   begin nk_m1_d = 3'd3; nr_d = 4'd10; end
        2'b01:   begin nk_m1_d = 3'd5; nr_d = 4'd12; end
        default: begin nk_m1_d = 3'd7; nr_d = 4'd14; end
      endcase
    end else if (state_q == GEN) begin
      i_d = i_q + 6'd1;
      j_d = (j_q == nk_m1_q) ? 3'd0 : j_q + 3'd1;
      if (i_q > {3'b000, nk_m1_q} && j_q == 3'd0)
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
      win_d[0] = w_new;
      for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];
      if (i_q[1:0] == 2'b11) begin
        rk_out_d   = {acc_q[0], acc_q[1], acc_q[2], w_new};
        rk_idx_d   = i_q[5:2];
        rk_valid_d = 1'b1;
      end else begin
        acc_d[i_q[1:0]] = w_new;
      end
      done_d = last_word;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q      <= '0;
      nk_m1_q    <= '0;
      nr_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      rcon_q     <= 8'h01;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
      for (int k = 0; k < 3; k++) acc_q[k] <= '0;
      rk_out_q   <= '0;
      rk_idx_q   <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      key_q      <= key_d;
      nk_m1_q    <= nk_m1_d;
      nr_q       <= nr_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      rk_out_q   <= rk_out_d;
      rk_idx_q   <= rk_idx_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      mode_err_q <= mode_err_d;
    end
  end

`ifdef AES_KEYSCHED_STORE_EN
  logic [RK_LEN-1:0] rf_q [15];
  logic [RK_LEN-1:0] rf_d [15];

  // Capture each round key as it is strobed out.
  always_comb begin
    rf_d = rf_q;
    if (rk_valid_d) rf_d[rk_idx_d] = rk_out_d;
  end

  // Round-key register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 15; k++) rf_q[k] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  // Indices beyond the last run's Nr read as zero.
  assign rk_rd_data = (rk_rd_idx <= nr_q) ? rf_q[rk_rd_idx] : '0;
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rk_rd_idx;
  assign rk_rd_data    = '0;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: known-answer table plus a
// reference-model scoreboard, mode error, ignored start, and mid-run reset.
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key_in;
  logic [1:0]   key_mode;
  logic         start;
  logic         busy, rk_valid, done, mode_err;
  logic [3:0]   rk_idx, rk_rd_idx;
  logic [127:0] rk_out, rk_rd_data;

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_mode(key_mode),
    .start(start), .busy(busy), .rk_valid(rk_valid), .rk_idx(rk_idx),
    .rk_out(rk_out), .done(done), .mode_err(mode_err),
    .rk_rd_idx(rk_rd_idx), .rk_rd_data(rk_rd_data)
  );

  typedef struct {
    logic [1:0]   mode;
    logic [255:0] key;
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
  } sb_t;

  sb_t          exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] cap [15];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h5555aaaa5555aaaa5555aaaa5555aaaa};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hdeadbeefcafef00d};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event want none", nm);
  endtask

  // GF(2^8) arithmetic for an independent S-box.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sb_calc(input logic [7:0] x);
    logic [7:0] inv, s, r;
    inv = 8'h00;
    for (int v = 1; v < 256; v++)
      if (gmul(x, v[7:0]) == 8'h01) inv = v[7:0];
    s = inv; r = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_calc(w[31:24]), sb_calc(w[23:16]), sb_calc(w[15:8]), sb_calc(w[7:0])};
  endfunction

  // Reference key expansion; pushes the expected round keys.
  task automatic model_push(input logic [1:0] mode, input logic [255:0] key, output int nr);
    int          nk;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    sb_t         e;
    nk = (mode == 2'b00) ? 4 : (mode == 2'b01) ? 6 : 8;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.idx = r[3:0];
      e.rk  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  // One schedule run; optional ignored start at inj_cyc, reset at abort_cyc.
  task automatic run(input logic [1:0] mode, input logic [255:0] key,
                     input int inj_cyc, input int abort_cyc);
    int  nr, nw, strobes;
    bit  fin;
    sb_t e;
    exp_q.delete();
    model_push(mode, key, nr);
    nw = 4 * (nr + 1);
    strobes = 0;
    fin = 1'b0;
    for (int k = 0; k < 15; k++) cap[k] = '0;
    @(negedge clk);
    key_in = key; key_mode = mode; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_rise", {127'b0, busy}, 128'd1);
    for (int cyc = 1; cyc <= nw + 8 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == inj_cyc);
      if (cyc == inj_cyc) begin
        key_mode = 2'b10;
        key_in   = ~key;
      end
      if (cyc == abort_cyc) begin
        reset = 1'b1;
        start = 1'b0;
        #1;
        chk("abort_ctl", {120'b0, busy, rk_valid, done, mode_err, rk_idx}, 128'd0);
        chk("abort_rk", rk_out, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          chk("post_abort", {125'b0, busy, rk_valid, done}, 128'd0);
        end
        $display("run mode=%0d aborted at cycle %0d", mode, cyc);
        fin = 1'b1;
      end else begin
        if (mode_err) fail("mode_err_in_run");
        if (rk_valid) begin
          strobes++;
          $display("rk mode=%0d idx=%0d key=%h", mode, rk_idx, rk_out);
          cap[rk_idx] = rk_out;
          if (exp_q.size() == 0) begin
            fail("extra_strobe");
          end else begin
            e = exp_q.pop_front();
            chk("rk_idx", {124'b0, rk_idx}, {124'b0, e.idx});
            chk("rk_out", rk_out, e.rk);
          end
        end
        if (done) begin
          fin = 1'b1;
          chk("done_cycle", cyc, nw);
          chk("done_with_valid", {127'b0, rk_valid}, 128'd1);
          chk("busy_fall", {127'b0, busy}, 128'd0);
          chk("strobe_count", strobes, nr + 1);
        end
      end
    end
    if (!fin) fail("timeout_done");
  endtask

  vec_t vt [6];

  initial begin
    reset = 1'b1; start = 1'b0; key_in = '0; key_mode = 2'b00; rk_rd_idx = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctl", {120'b0, busy, rk_valid, done, mode_err, rk_idx}, 128'd0);
    chk("reset_rk", rk_out, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ctl", {120'b0, busy, rk_valid, done, mode_err, rk_idx}, 128'd0);

    vt[0] = '{2'b00, K128, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    vt[1] = '{2'b00, K128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vt[2] = '{2'b00, K128, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vt[3] = '{2'b01, K192, 4'd12, 128'ha4970a331a78dc09c418c271e3a41d5d};
    vt[4] = '{2'b10, K256, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vt[5] = '{2'b10, K256, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
    for (int v = 0; v < 6; v++) begin
      run(vt[v].mode, vt[v].key, -1, -1);
      chk($sformatf("kat%0d", v), cap[vt[v].idx], vt[v].exp);
    end

    // Reserved mode: one-cycle error pulse, no run.
    @(negedge clk);
    key_mode = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mode_err_pulse", {126'b0, mode_err, busy}, 128'd2);
    @(posedge clk); #1;
    chk("mode_err_clear", {126'b0, mode_err, busy}, 128'd0);
    $display("reserved mode start checked");

    // Start during a run is ignored.
    run(2'b00, K128, 10, -1);
    chk("inj_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset mid AES-256, then a clean AES-128 run.
    run(2'b10, K256, -1, 20);
    run(2'b00, K128, -1, -1);
    chk("after_abort_rk1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("after_abort_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEYSCHED_STORE_EN
    rk_rd_idx = 4'd10; #1;
    chk("rd_idx10", rk_rd_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rk_rd_idx = 4'd12; #1;
    chk("rd_idx12", rk_rd_data, 128'd0);
`else
    rk_rd_idx = 4'd10; #1;
    chk("rd_tied0", rk_rd_data, 128'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
